// File: rtl/aes256_key_sched.sv
// On-the-fly AES-256 round-key generator: rk0..rk14, one per inNext, rewindable from the stored key.
// 1-cycle load/rewind/next; key load refused while ACTIVE (outKeyReady=0). Optional outErr via AES_KS_ERR_EN.
module aes256_key_sched (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inKeyValid,
  input  logic [255:0] inKey,
  output logic         outKeyReady,
  input  logic         inNext,
  input  logic         inRewind,
  output logic [127:0] outRoundKey,
  output logic         outRoundKeyValid,
  output logic [3:0]   outRound,
  output logic         outLast
`ifdef AES_KS_ERR_EN
  ,
  output logic         outErr
`endif
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_LAST} state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [255:0]   r_key;
  logic [127:0]   r_a;
  logic [127:0]   r_b;
  logic [3:0]     r_round;
  logic           w_load;
  logic           w_rewind;
  logic           w_next;
  logic [31:0]    w_b3;
  logic [7:0]     w_rcon;
  logic [31:0]    w_t;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;

  assign w_load   = inKeyValid && (r_state != S_ACTIVE);
  assign w_rewind = inRewind && (r_state != S_IDLE);
  assign w_next   = inNext && (r_state == S_ACTIVE);

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    outKeyReady      = (r_state != S_ACTIVE);
    outRoundKeyValid = (r_state != S_IDLE);
    if (w_load || w_rewind) w_state_nxt = S_ACTIVE;
    else if (w_next)        w_state_nxt = (r_round == 4'd13) ? S_LAST : S_ACTIVE;
  end

  // Next-next key: even rounds take the RotWord/Rcon step, odd rounds the extra SubWord of Nk=8.
  assign w_b3   = r_b[31:0];
  assign w_rcon = 8'h01 << r_round[3:1];
  assign w_t    = r_round[0] ? sub_word(w_b3)
                             : (sub_word({w_b3[23:0], w_b3[31:24]}) ^ {w_rcon, 24'h0});
  assign w_n0   = r_a[127:96] ^ w_t;
  assign w_n1   = r_a[95:64]  ^ w_n0;
  assign w_n2   = r_a[63:32]  ^ w_n1;
  assign w_n3   = r_a[31:0]   ^ w_n2;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      r_key   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_round <= '0;
    end else if (w_load) begin
      r_key   <= inKey;
      r_a     <= inKey[255:128];
      r_b     <= inKey[127:0];
      r_round <= '0;
    end else if (w_rewind) begin
      r_a     <= r_key[255:128];
      r_b     <= r_key[127:0];
      r_round <= '0;
    end else if (w_next) begin
      r_a     <= r_b;
      r_b     <= {w_n0, w_n1, w_n2, w_n3};
      r_round <= r_round + 4'd1;
    end
  end

  assign outRoundKey = r_a;
  assign outRound    = r_round;
  assign outLast     = (r_round == 4'd14);

`ifdef AES_KS_ERR_EN
  logic r_err;
  logic w_err_evt;

  assign w_err_evt = (inNext && (r_state != S_ACTIVE))
                   || (inRewind && (r_state == S_IDLE))
                   || (inKeyValid && (r_state == S_ACTIVE));

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN)        r_err <= 1'b0;
    else if (w_load)    r_err <= 1'b0;
    else if (w_err_evt) r_err <= 1'b1;
  end

  assign outErr = r_err;
`endif

endmodule
